// File: rtl/csi2_packet_ctrl_pkg.sv
// csi2_packet_ctrl_pkg: shared CSI-2 receive constants.
// Data types, FSM encoding, header byte positions, ECC masks.
package csi2_packet_ctrl_pkg;

   localparam logic [5:0] DT_FS        = 6'h00;
   localparam logic [5:0] DT_FE        = 6'h01;
   localparam logic [5:0] DT_LS        = 6'h02;
   localparam logic [5:0] DT_LE        = 6'h03;
   localparam logic [5:0] DT_SHORT_MAX = 6'h0F;

   // word0 = {WC[7:0], DI}, word1 = {ECC, WC[15:8]}
   localparam int HDR_DI_LSB  = 0;
   localparam int HDR_WCL_LSB = 8;
   localparam int HDR_WCH_LSB = 0;
   localparam int HDR_ECC_LSB = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR1,
      ST_PAYLOAD,
      ST_CRC,
      ST_DONE
   } state_t;

   // Hamming parity masks over D[23:0] = {WC, DI}
   localparam logic [5:0][23:0] ECC_MASK = {
      24'hEFFC00,
      24'hDF03F0,
      24'hB8E38E,
      24'h749A6D,
      24'hF2555B,
      24'hF12CB7
   };

endpackage

// File: rtl/csi2_packet_ctrl_if.sv
// csi2_packet_ctrl_if: aligned word stream in, packet events out.
// master = aligner/pipeline side, slave = packet controller.
interface csi2_packet_ctrl_if;

   logic        enable;
   logic [15:0] word_data;
   logic        word_valid;
   logic        align_invalid;
   logic        packet_done;
   logic        hdr_valid;
   logic [7:0]  pkt_di;
   logic [15:0] pkt_wc;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        pix_last;
   logic        frame_start;
   logic        frame_end;
   logic        line_start;
   logic        line_end;
   logic        ecc_err;
   logic        len_err;
   logic        sync_err;

   modport master (
      output enable, word_data, word_valid, align_invalid,
      input  packet_done, hdr_valid, pkt_di, pkt_wc,
      input  pix_data, pix_valid, pix_last,
      input  frame_start, frame_end, line_start, line_end,
      input  ecc_err, len_err, sync_err
   );

   modport slave (
      input  enable, word_data, word_valid, align_invalid,
      output packet_done, hdr_valid, pkt_di, pkt_wc,
      output pix_data, pix_valid, pix_last,
      output frame_start, frame_end, line_start, line_end,
      output ecc_err, len_err, sync_err
   );

endinterface

// File: rtl/csi2_packet_ctrl_ecc_calc.sv
// csi2_ecc_calc: combinational CSI-2 header ECC.
// i_data = {WC, DI} (24b), o_ecc = 6-bit Hamming parity.
module csi2_ecc_calc
   import csi2_packet_ctrl_pkg::*;
(
   input  logic [23:0] i_data,
   output logic [5:0]  o_ecc
);

   always_comb begin
      o_ecc = '0;
      for (int i = 0; i < 6; i++) begin
         o_ecc[i] = ^(i_data & ECC_MASK[i]);
      end
   end

endmodule

// File: rtl/csi2_packet_ctrl.sv
// csi2_packet_ctrl: CSI-2 2-lane packet parser/sequencer.
// Ports: sys_clk, sys_rst (async low), bus (slave modport).
module csi2_packet_ctrl
   import csi2_packet_ctrl_pkg::*;
#(
   parameter int MAX_PAYLOAD_WORDS = 2048,
   parameter int VC_FILTER_EN      = 0,
   parameter int VC_SEL            = 0
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   csi2_packet_ctrl_if.slave bus
);

   localparam int CW = $clog2(MAX_PAYLOAD_WORDS) + 1;
   localparam logic [1:0] VC_ACC = VC_SEL[1:0];

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [15:0]   r_hdr0;
   logic [15:0]   r_pkt_wc;
   logic [15:0]   r_pix_data;
   logic [7:0]    r_pkt_di;
   logic          r_rearm;
   logic          r_miss;
   logic          r_fwd;
   logic          r_hdr_valid;
   logic          r_pix_valid;
   logic          r_pix_last;
   logic          r_ecc_err;
   logic          r_len_err;
   logic          r_sync_err;
   logic [3:0]    r_sync;

   logic [7:0]    w_di;
   logic [15:0]   w_wc;
   logic [5:0]    w_ecc;
   logic          w_ecc_ok;
   logic          w_short;
   logic          w_len_bad;
   logic          w_vc_ok;
   logic          w_busy;
   logic          w_lost;
   logic          w_last;
   logic          w_take;
   logic          w_hdr_valid;
   logic          w_pix_take;
   logic          w_pix_valid;
   logic          w_pix_last;
   logic          w_ecc_err;
   logic          w_len_err;
   logic          w_sync_err;
   logic [3:0]    w_sync;
   logic          w_packet_done;

   assign w_di = r_hdr0[HDR_DI_LSB +: 8];
   assign w_wc = {bus.word_data[HDR_WCH_LSB +: 8],
                  r_hdr0[HDR_WCL_LSB +: 8]};

   csi2_ecc_calc u_ecc (
      .i_data ({w_wc, w_di}),
      .o_ecc  (w_ecc)
   );

   // ECC[7:6] are reserved and must arrive as zero
   assign w_ecc_ok  = bus.word_data[HDR_ECC_LSB +: 8]
                      == {2'b00, w_ecc};
   assign w_short   = w_di[5:0] <= DT_SHORT_MAX;
   assign w_len_bad = w_wc[0] ||
                      (32'(w_wc[15:1]) > MAX_PAYLOAD_WORDS);
   assign w_vc_ok   = (VC_FILTER_EN == 0) ||
                      (w_di[7:6] == VC_ACC);
   assign w_busy    = (r_state == ST_HDR1) ||
                      (r_state == ST_PAYLOAD) ||
                      (r_state == ST_CRC);
   // second consecutive missing word inside a packet
   assign w_lost    = w_busy && !bus.word_valid && r_miss;
   assign w_last    = r_cnt == CW'(1);
   assign w_take    = (r_state == ST_IDLE) &&
                      (w_state_nxt == ST_HDR1);

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (bus.word_valid && bus.enable && r_rearm &&
                !bus.align_invalid)
               w_state_nxt = ST_HDR1;
         end
         ST_HDR1: begin
            if (bus.align_invalid || w_lost)
               w_state_nxt = ST_DONE;
            else if (bus.word_valid) begin
               if (!w_ecc_ok || w_short || w_len_bad)
                  w_state_nxt = ST_DONE;
               else if (w_wc == 16'd0)
                  w_state_nxt = ST_CRC;
               else
                  w_state_nxt = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (bus.word_valid && w_last)
               w_state_nxt = bus.align_invalid ? ST_DONE : ST_CRC;
            else if (bus.align_invalid || w_lost)
               w_state_nxt = ST_DONE;
         end
         ST_CRC: begin
            if (bus.align_invalid || w_lost || bus.word_valid)
               w_state_nxt = ST_DONE;
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_hdr_valid   = 1'b0;
      w_pix_take    = 1'b0;
      w_pix_valid   = 1'b0;
      w_pix_last    = 1'b0;
      w_ecc_err     = 1'b0;
      w_len_err     = 1'b0;
      w_sync_err    = 1'b0;
      w_sync        = '0;
      w_cnt_nxt     = r_cnt;
      w_packet_done = 1'b0;
      unique case (r_state)
         ST_IDLE: w_sync_err = bus.align_invalid;
         ST_HDR1: begin
            if (bus.align_invalid || w_lost)
               w_sync_err = 1'b1;
            else if (bus.word_valid) begin
               w_hdr_valid = 1'b1;
               if (!w_ecc_ok)
                  w_ecc_err = 1'b1;
               else if (w_short) begin
                  if (w_vc_ok && (w_di[5:2] == 4'd0))
                     w_sync = 4'b0001 << w_di[1:0];
               end else if (w_len_bad)
                  w_len_err = 1'b1;
               else
                  w_cnt_nxt = w_wc[CW:1];
            end
         end
         ST_PAYLOAD: begin
            // a word racing align_invalid is kept only if final
            if (bus.word_valid &&
                (w_last || !bus.align_invalid)) begin
               w_pix_take  = 1'b1;
               w_pix_valid = r_fwd;
               w_pix_last  = r_fwd && w_last;
               w_cnt_nxt   = r_cnt - CW'(1);
            end
            w_sync_err = bus.align_invalid || w_lost;
         end
         ST_CRC:  w_sync_err = bus.align_invalid || w_lost;
         ST_DONE: w_packet_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         r_cnt       <= '0;
         r_hdr0      <= '0;
         r_pkt_di    <= '0;
         r_pkt_wc    <= '0;
         r_pix_data  <= '0;
         r_rearm     <= 1'b1;
         r_miss      <= 1'b0;
         r_fwd       <= 1'b0;
         r_hdr_valid <= 1'b0;
         r_pix_valid <= 1'b0;
         r_pix_last  <= 1'b0;
         r_ecc_err   <= 1'b0;
         r_len_err   <= 1'b0;
         r_sync_err  <= 1'b0;
         r_sync      <= '0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_hdr_valid <= w_hdr_valid;
         r_pix_valid <= w_pix_valid;
         r_pix_last  <= w_pix_last;
         r_ecc_err   <= w_ecc_err;
         r_len_err   <= w_len_err;
         r_sync_err  <= w_sync_err;
         r_sync      <= w_sync;
         r_miss      <= w_busy && !bus.word_valid;
         if (w_take) r_hdr0 <= bus.word_data;
         if (w_hdr_valid) begin
            r_pkt_di <= w_di;
            r_pkt_wc <= w_wc;
            r_fwd    <= w_vc_ok;
         end
         if (w_pix_take) r_pix_data <= bus.word_data;
         // a held stream after packet_done must not be reparsed
         if (!bus.word_valid)
            r_rearm <= 1'b1;
         else if (r_state == ST_DONE)
            r_rearm <= 1'b0;
      end
   end

   assign bus.packet_done = w_packet_done;
   assign bus.hdr_valid   = r_hdr_valid;
   assign bus.pkt_di      = r_pkt_di;
   assign bus.pkt_wc      = r_pkt_wc;
   assign bus.pix_data    = r_pix_data;
   assign bus.pix_valid   = r_pix_valid;
   assign bus.pix_last    = r_pix_last;
   assign bus.frame_start = r_sync[0];
   assign bus.frame_end   = r_sync[1];
   assign bus.line_start  = r_sync[2];
   assign bus.line_end    = r_sync[3];
   assign bus.ecc_err     = r_ecc_err;
   assign bus.len_err     = r_len_err;
   assign bus.sync_err    = r_sync_err;

endmodule

// File: tb/tb_csi2_packet_ctrl.sv
// tb_csi2_packet_ctrl: directed bench for csi2_packet_ctrl.
// Payload words are scoreboarded; events are counted per step.
module tb_csi2_packet_ctrl;

   localparam int MAXW = 2048;

   logic sys_clk = 1'b0;
   logic sys_rst;

   always #5 sys_clk = ~sys_clk;

   csi2_packet_ctrl_if bus ();

   csi2_packet_ctrl #(
      .MAX_PAYLOAD_WORDS (MAXW),
      .VC_FILTER_EN      (0),
      .VC_SEL            (0)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   typedef struct packed {
      logic [15:0] d;
      logic        last;
   } pix_t;

   pix_t expq[$];

   int vectors     = 0;
   int miscompares = 0;
   int n_hdr, n_done, n_pix, n_last;
   int n_fs, n_fe, n_ls, n_le;
   int n_ecc, n_len, n_sync;

   function automatic logic [5:0] ecc_ref(logic [23:0] d);
      logic [5:0] e;
      e[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]
           ^ d[16]^d[20]^d[21]^d[22]^d[23];
      e[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]
           ^ d[17]^d[20]^d[21]^d[22]^d[23];
      e[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]
           ^ d[18]^d[20]^d[21]^d[22];
      e[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]
           ^ d[19]^d[20]^d[21]^d[23];
      e[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]
           ^ d[19]^d[20]^d[22]^d[23];
      e[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]
           ^ d[18]^d[19]^d[21]^d[22]^d[23];
      return e;
   endfunction

   task automatic chk(string tag, logic [31:0] obs,
                      logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic observe();
      pix_t e;
      if (bus.pix_valid === 1'b1) begin
         if (expq.size() == 0) begin
            chk("pix_unexpected", bus.pix_valid, 0);
         end else begin
            e = expq.pop_front();
            chk("pix_data", bus.pix_data, e.d);
            chk("pix_last", bus.pix_last, e.last);
         end
         n_pix++;
         if (bus.pix_last === 1'b1) n_last++;
      end
      if (bus.hdr_valid === 1'b1)   n_hdr++;
      if (bus.packet_done === 1'b1) n_done++;
      if (bus.frame_start === 1'b1) n_fs++;
      if (bus.frame_end === 1'b1)   n_fe++;
      if (bus.line_start === 1'b1)  n_ls++;
      if (bus.line_end === 1'b1)    n_le++;
      if (bus.ecc_err === 1'b1)     n_ecc++;
      if (bus.len_err === 1'b1)     n_len++;
      if (bus.sync_err === 1'b1)    n_sync++;
   endtask

   task automatic cyc(logic v, logic [15:0] d, logic ai);
      bus.word_valid    = v;
      bus.word_data     = d;
      bus.align_invalid = ai;
      @(posedge sys_clk);
      #1;
      observe();
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, 1'b0);
   endtask

   task automatic clr();
      n_hdr = 0; n_done = 0; n_pix = 0; n_last = 0;
      n_fs = 0; n_fe = 0; n_ls = 0; n_le = 0;
      n_ecc = 0; n_len = 0; n_sync = 0;
   endtask

   task automatic hdr(logic [7:0] di, logic [15:0] wc,
                      logic bad);
      logic [5:0] e;
      e = ecc_ref({wc, di});
      if (bad) e = e ^ 6'h01;
      cyc(1'b1, {wc[7:0], di}, 1'b0);
      cyc(1'b1, {2'b00, e, wc[15:8]}, 1'b0);
   endtask

   task automatic pay(logic [15:0] d, logic last);
      pix_t p;
      p.d    = d;
      p.last = last;
      expq.push_back(p);
      cyc(1'b1, d, 1'b0);
   endtask

   function automatic logic [31:0] outs();
      return {bus.packet_done, bus.hdr_valid, bus.pix_valid,
              bus.pix_last, bus.frame_start, bus.frame_end,
              bus.line_start, bus.line_end, bus.ecc_err,
              bus.len_err, bus.sync_err};
   endfunction

   initial begin
      clr();
      sys_rst           = 1'b0;
      bus.enable        = 1'b1;
      bus.word_valid    = 1'b0;
      bus.word_data     = 16'h0000;
      bus.align_invalid = 1'b0;
      #1;
      chk("rst_pulses", outs(), 0);
      chk("rst_di", bus.pkt_di, 0);
      chk("rst_wc", bus.pkt_wc, 0);
      chk("rst_pix", bus.pix_data, 0);
      repeat (3) @(posedge sys_clk);
      #1 sys_rst = 1'b1;
      idle(2);

      // short frame start
      clr();
      hdr(8'h00, 16'h0000, 1'b0);
      chk("fs_done_at_word1+1", bus.packet_done, 1);
      chk("fs_pulse", bus.frame_start, 1);
      chk("fs_hdr_valid", bus.hdr_valid, 1);
      idle(3);
      chk("fs_hdr_cnt", n_hdr, 1);
      chk("fs_cnt", n_fs, 1);
      chk("fs_done_cnt", n_done, 1);
      chk("fs_pix_cnt", n_pix, 0);

      // long RAW10 packet, WC=8
      clr();
      hdr(8'h2B, 16'd8, 1'b0);
      for (int i = 0; i < 4; i++)
         pay(16'hA000 + 16'(i * 16'h0111), i == 3);
      cyc(1'b1, 16'hC3C3, 1'b0);
      chk("raw_done_after_crc", bus.packet_done, 1);
      idle(3);
      chk("raw_di", bus.pkt_di, 8'h2B);
      chk("raw_wc", bus.pkt_wc, 16'd8);
      chk("raw_pix_cnt", n_pix, 4);
      chk("raw_last_cnt", n_last, 1);
      chk("raw_done_cnt", n_done, 1);
      chk("raw_q_empty", expq.size(), 0);

      // frame end with corrupted ECC
      clr();
      hdr(8'h01, 16'h0000, 1'b1);
      idle(3);
      chk("ecc_err_cnt", n_ecc, 1);
      chk("ecc_fe_cnt", n_fe, 0);
      chk("ecc_done_cnt", n_done, 1);

      // odd word count
      clr();
      hdr(8'h2B, 16'd7, 1'b0);
      idle(3);
      chk("odd_len_err", n_len, 1);
      chk("odd_pix_cnt", n_pix, 0);
      chk("odd_done_cnt", n_done, 1);

      // one word beyond the payload limit
      clr();
      hdr(8'h2B, 16'(2 * MAXW + 2), 1'b0);
      idle(3);
      chk("big_len_err", n_len, 1);
      chk("big_pix_cnt", n_pix, 0);
      chk("big_done_cnt", n_done, 1);

      // exactly the payload limit is accepted
      clr();
      hdr(8'h2B, 16'(2 * MAXW), 1'b0);
      for (int i = 0; i < MAXW; i++)
         pay(16'(i) ^ 16'h5A5A, i == MAXW - 1);
      cyc(1'b1, 16'h0F0F, 1'b0);
      idle(3);
      chk("max_len_err", n_len, 0);
      chk("max_pix_cnt", n_pix, MAXW);
      chk("max_last_cnt", n_last, 1);
      chk("max_done_cnt", n_done, 1);

      // align_invalid after 2 of 4 payload words
      clr();
      hdr(8'h2B, 16'd8, 1'b0);
      pay(16'h1234, 1'b0);
      pay(16'h5678, 1'b0);
      cyc(1'b1, 16'hDEAD, 1'b1);
      chk("abort_sync_err", bus.sync_err, 1);
      chk("abort_done", bus.packet_done, 1);
      idle(2);
      hdr(8'h02, 16'h0000, 1'b0);
      idle(2);
      chk("abort_pix_cnt", n_pix, 2);
      chk("abort_last_cnt", n_last, 0);
      chk("abort_sync_cnt", n_sync, 1);
      chk("abort_next_ls", n_ls, 1);
      chk("abort_hdr_cnt", n_hdr, 2);
      chk("abort_done_cnt", n_done, 2);

      // held word_valid after packet_done must not reparse
      clr();
      hdr(8'h03, 16'h0000, 1'b0);
      cyc(1'b1, 16'h0000, 1'b0);
      cyc(1'b1, 16'h0000, 1'b0);
      cyc(1'b1, 16'h0000, 1'b0);
      chk("hold_no_hdr", n_hdr, 1);
      idle(1);
      hdr(8'h00, 16'h0000, 1'b0);
      idle(2);
      chk("hold_hdr_cnt", n_hdr, 2);
      chk("hold_le_cnt", n_le, 1);
      chk("hold_fs_cnt", n_fs, 1);
      chk("hold_done_cnt", n_done, 2);

      // single-cycle word_valid gap is tolerated
      clr();
      hdr(8'h2B, 16'd4, 1'b0);
      pay(16'hBEEF, 1'b0);
      idle(1);
      pay(16'hCAFE, 1'b1);
      cyc(1'b1, 16'h7777, 1'b0);
      idle(2);
      chk("gap1_pix_cnt", n_pix, 2);
      chk("gap1_last_cnt", n_last, 1);
      chk("gap1_sync_cnt", n_sync, 0);
      chk("gap1_done_cnt", n_done, 1);

      // two-cycle gap aborts the packet
      clr();
      hdr(8'h2B, 16'd4, 1'b0);
      pay(16'h4321, 1'b0);
      idle(2);
      chk("gap2_sync_err", bus.sync_err, 1);
      idle(2);
      chk("gap2_pix_cnt", n_pix, 1);
      chk("gap2_last_cnt", n_last, 0);
      chk("gap2_sync_cnt", n_sync, 1);
      chk("gap2_done_cnt", n_done, 1);

      // asynchronous reset mid-payload
      clr();
      hdr(8'h2B, 16'd8, 1'b0);
      pay(16'h1111, 1'b0);
      pay(16'h2222, 1'b0);
      chk("rst2_pix_before", bus.pix_valid, 1);
      #2 sys_rst = 1'b0;
      #1;
      chk("rst2_pulses", outs(), 0);
      chk("rst2_pix", bus.pix_data, 0);
      chk("rst2_di", bus.pkt_di, 0);
      chk("rst2_wc", bus.pkt_wc, 0);
      bus.word_valid = 1'b0;
      @(posedge sys_clk);
      #1 sys_rst = 1'b1;
      idle(2);
      clr();
      hdr(8'h00, 16'h0000, 1'b0);
      idle(2);
      chk("rst2_fs_cnt", n_fs, 1);
      chk("rst2_done_cnt", n_done, 1);
      chk("rst2_pix_cnt", n_pix, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/csi2_packet_ctrl.md
Name: csi2_packet_ctrl

Overview:
Sequences the 2-lane CSI-2 receive path downstream of the lane word aligner. It consumes the aligned 16-bit word stream and parses the packet header. It then counts long-packet payload and CRC words and generates the packet_done pulse that re-arms the aligner. It emits pixel words, short-packet sync events and error flags to the image pipeline.

Parameters:
MAX_PAYLOAD_WORDS, 2048, largest accepted long-packet payload in 16-bit words; larger WC aborts.
VC_FILTER_EN, 0, 1 = forward only packets whose virtual channel equals VC_SEL.
VC_SEL, 0, 2-bit virtual channel accepted when VC_FILTER_EN=1.

Ports:
sys_clk  in  1  receive byte clock
sys_rst  in  1  asynchronous active-low reset
enable  in  1  0 = stay in IDLE and ignore words
word_data  in  16  aligned word, low byte = earlier byte (lane 0)
word_valid  in  1  level; high every cycle a word is present
align_invalid  in  1  one-cycle lane-skew error pulse from the aligner
packet_done  out  1  one-cycle pulse that ends the packet in the aligner
hdr_valid  out  1  one-cycle pulse; pkt_di/pkt_wc updated
pkt_di  out  8  data identifier {VC[1:0], DT[5:0]}
pkt_wc  out  16  word count / short-packet data field
pix_data  out  16  payload word
pix_valid  out  1  payload word strobe
pix_last  out  1  with final payload word
frame_start, frame_end, line_start, line_end  out  1 each  pulses for DT 0x00/0x01/0x02/0x03
ecc_err  out  1  pulse: header ECC mismatch
len_err  out  1  pulse: odd WC or WC/2 > MAX_PAYLOAD_WORDS
sync_err  out  1  pulse: align_invalid seen or word_valid dropped mid-packet

Behaviour:
- Reset (async, sys_rst=0): all outputs 0; state IDLE; rearm=1.
- Header layout: word0 = {WC[7:0], DI}; word1 = {ECC, WC[15:8]}.
- States: IDLE, HDR1, PAYLOAD, CRC, DONE.
- IDLE: takes word0 when word_valid & enable & rearm → HDR1.
- HDR1, on word_valid:
  - Computes ECC over {WC, DI} (CSI-2 Hamming 24-bit table; ECC[7:6] must be 0).
  - Registers pkt_di/pkt_wc and pulses hdr_valid on the following cycle.
  - ECC mismatch → ecc_err pulse, DONE.
  - DT ≤ 0x0F (short packet) → sync pulse for DT 0x00–0x03, DONE.
  - Long packet, WC odd or WC/2 > MAX_PAYLOAD_WORDS → len_err, DONE.
  - Long packet, WC=0 → CRC.
  - Long packet otherwise → load down-counter with WC/2, PAYLOAD.
- PAYLOAD: each word_valid cycle forwards the word, 1-cycle latency (pix_data/pix_valid registered) and decrements the counter. pix_last goes high with the word where the counter = 1. That word → CRC.
- VC filter: if VC_FILTER_EN and VC≠VC_SEL, counting still occurs but pix_valid and the sync pulses are suppressed.
- CRC: one word_valid cycle consumes the CRC (not checked; not forwarded) → DONE.
- DONE: packet_done=1 for exactly one cycle; rearm cleared; → IDLE. Words arriving in DONE are ignored.
- rearm sets on any cycle word_valid=0. This prevents reparsing the held aligner stream after packet_done.
- word_valid low in HDR1/PAYLOAD/CRC: the counter holds for up to 1 cycle. A second consecutive low cycle → sync_err, DONE.
- align_invalid in any state other than IDLE/DONE → sync_err, DONE (partial payload is not marked pix_last).
- align_invalid in IDLE → sync_err only.
- Simultaneous align_invalid and last payload word: the word is forwarded with pix_last, sync_err is pulsed, and the block goes to DONE (skipping CRC).
- enable deassert mid-packet: the packet completes normally; the block stays in IDLE afterwards.
- Counter width: clog2(MAX_PAYLOAD_WORDS)+1; no wrap is possible because WC is checked first.

Decomposition:
- Shared package csi2_pkg: DT constants (FS=0x00, FE=0x01, LS=0x02, LE=0x03, short-packet limit 0x0F), state encoding, header byte positions.
- One sub-module: csi2_ecc_calc (combinational 24→6-bit ECC), reusable by a future TX path.

Test Plan:
- Short FS packet, words 0x0000,0x0000-with-valid-ECC (DI=0x00, WC=0) → hdr_valid, frame_start pulse, packet_done 1 cycle after word1, no pix_valid.
- Long RAW10 packet DI=0x2B, WC=8 → 4 pix_valid words matching input one cycle later, pix_last on 4th, CRC word consumed, packet_done once.
- Corrupted ECC byte on FE packet → ecc_err pulse, no frame_end, packet_done.
- WC=7, then separately WC=2*MAX_PAYLOAD_WORDS+2 → len_err each, no pix_valid, packet_done.
- align_invalid pulse after 2 of 4 payload words → sync_err, packet_done, no pix_last; the next packet after word_valid low parses correctly.
- word_valid held high for 3 cycles after packet_done → no hdr_valid until word_valid has gone low and a new header arrives; reset asserted mid-PAYLOAD clears all outputs immediately.
